// File: rtl/rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package rx_pkg;

  localparam int RX_IO_BITS           = 2;
  localparam int RX_PAYLOAD_BITS      = 16;
  localparam int RX_SYMBOLS_PER_FRAME = RX_PAYLOAD_BITS / RX_IO_BITS;

  localparam logic [RX_IO_BITS-1:0] RX_IDLE_SYMBOL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
// While empty, the head output holds the last word popped (0 after reset).
module rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

  // NOTE: storage is not reset; an empty FIFO never exposes it, so reset would only cost flops.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/rx_frame_receiver.sv
// Deserializes 2-bit serial frames into payload words and buffers them in rx_fifo.
// Build option: define RX_PARITY_EN to insert an even-parity symbol before stop.
module rx_frame_receiver
  import rx_pkg::*;
#(
  parameter int IO_BITS      = RX_IO_BITS,
  parameter int PAYLOAD_BITS = RX_PAYLOAD_BITS,
  parameter int DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IO_BITS-1:0]      rx_pins,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic                    overflow,
  input  logic                    clear_ovf,
  output logic                    busy
);

  localparam int SYMS = PAYLOAD_BITS / IO_BITS;
  localparam int SW   = (SYMS > 1) ? $clog2(SYMS) : 1;

  rx_state_e               r_state;
  rx_state_e               w_next_state;
  logic [SW-1:0]           r_sym_cnt;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_frame_err;
  logic                    r_overflow;
  logic                    w_last_sym;
  logic                    w_par_err;
  logic                    w_stop_ok;
  logic                    w_good;
  logic                    w_bad;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;

  assign w_last_sym = (r_sym_cnt == SW'(SYMS - 1));

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:   if (!rx_pins[0]) w_next_state = DATA;
`ifdef RX_PARITY_EN
      DATA:   if (w_last_sym) w_next_state = PARITY;
`else
      DATA:   if (w_last_sym) w_next_state = STOP;
`endif
      PARITY: w_next_state = STOP;
      STOP:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sym_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DATA) begin
        r_sym_cnt <= r_sym_cnt + 1'b1;
        r_shift   <= {rx_pins, r_shift[PAYLOAD_BITS-1:IO_BITS]};
      end else begin
        r_sym_cnt <= '0;
      end
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_err;

  // Every frame passes through PARITY before STOP, so this is always fresh at the stop sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (r_state == PARITY) begin
      r_par_err <= (rx_pins[0] != ^r_shift) || !rx_pins[1];
    end
  end

  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  assign w_stop_ok = (rx_pins == RX_IDLE_SYMBOL) && !w_par_err;
  assign w_good    = (r_state == STOP) && w_stop_ok;
  assign w_bad     = (r_state == STOP) && !w_stop_ok;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_good && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_good && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clear_ovf)             r_overflow <= 1'b0;
    end
  end

  rx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Scoreboard bench for rx_frame_receiver: stimulus queues expected words, a monitor pops and compares.
module tb_rx_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rx_pins;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        overflow;
  logic        clear_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int err_base;
  logic [15:0] exp_q[$];

  rx_frame_receiver #(.IO_BITS(2), .PAYLOAD_BITS(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pins   (rx_pins),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, where all inputs are settled.
  initial begin
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      #1;
      if (frame_err === 1'b1) err_seen++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got=%0h required=none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {16'h0, out_data}, {16'h0, exp_w});
        end
      end
    end
  end

  task automatic drive(input logic [1:0] s);
    @(negedge clk);
    rx_pins = s;
  endtask

  // Leaves the stop symbol on the pins; caller's next drive ends it.
  task automatic send_frame(input logic [15:0] d, input logic [1:0] stop,
                            input logic par, input logic pop_at_stop);
    drive(2'b10);
    for (int i = 0; i < 8; i++) drive(d[2*i +: 2]);
`ifdef RX_PARITY_EN
    drive({1'b1, par});
`else
    if (par === 1'bz) $display("parity symbol not used in this build");
`endif
    @(negedge clk);
    rx_pins = stop;
    if (pop_at_stop) out_ready = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_pins   = 2'b11;
    out_ready = 1'b1;
    clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow",  overflow, 0);
    check("rst_busy",      busy, 0);

    // Single good frame: valid for one cycle after the stop sample.
    err_base = err_seen;
    exp_q.push_back(16'hA5C3);
    send_frame(16'hA5C3, 2'b11, ^16'hA5C3, 1'b0);
    #1;
    check("busy_in_stop", busy, 1);
    @(negedge clk);
    rx_pins = 2'b11;
    #1;
    check("t1_valid_rise", out_valid, 1);
    check("t1_data", out_data, 16'hA5C3);
    @(negedge clk);
    #1;
    check("t1_valid_fall", out_valid, 0);
    check("t1_data_hold", out_data, 16'hA5C3);
    check("t1_busy_idle", busy, 0);
    check("t1_no_err", err_seen - err_base, 0);

    // Bad stop symbol.
    err_base = err_seen;
    send_frame(16'h1234, 2'b01, ^16'h1234, 1'b0);
    @(negedge clk);
    rx_pins = 2'b11;
    #1;
    check("t2_err_pulse", frame_err, 1);
    check("t2_no_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("t2_err_fall", frame_err, 0);
    @(negedge clk);
    check("t2_err_count", err_seen - err_base, 1);

    // Overflow with a stalled consumer, three back-to-back frames.
    err_base  = err_seen;
    out_ready = 1'b0;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    send_frame(16'h0001, 2'b11, ^16'h0001, 1'b0);
    send_frame(16'h0002, 2'b11, ^16'h0002, 1'b0);
    send_frame(16'h0003, 2'b11, ^16'h0003, 1'b0);
    @(negedge clk);
    rx_pins = 2'b11;
    #1;
    check("t3_overflow", overflow, 1);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_data, 16'h0001);
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    check("t3_ovf_sticky", overflow, 1);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    #1;
    check("t3_ovf_cleared", overflow, 0);
    check("t3_no_err", err_seen - err_base, 0);

    // Full FIFO, pop coincides with the stop sample of a new frame.
    out_ready = 1'b0;
    exp_q.push_back(16'h0AAA);
    exp_q.push_back(16'h0BBB);
    exp_q.push_back(16'h0BEE);
    send_frame(16'h0AAA, 2'b11, ^16'h0AAA, 1'b0);
    send_frame(16'h0BBB, 2'b11, ^16'h0BBB, 1'b0);
    send_frame(16'h0BEE, 2'b11, ^16'h0BEE, 1'b1);
    @(negedge clk);
    rx_pins = 2'b11;
    #1;
    check("t4_no_overflow", overflow, 0);
    wait_drain();

    // Reset in the middle of the data symbols.
    err_base = err_seen;
    drive(2'b10);
    for (int i = 0; i < 4; i++) drive(2'b01);
    #1;
    check("t5_busy_mid", busy, 1);
    @(negedge clk);
    rx_pins = 2'b01;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    rx_pins = 2'b11;
    #1;
    check("t5_busy_after_rst", busy, 0);
    check("t5_no_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    check("t5_still_idle", busy, 0);
    check("t5_no_push", out_valid, 0);
    check("t5_no_err", err_seen - err_base, 0);
    exp_q.push_back(16'hFFFF);
    send_frame(16'hFFFF, 2'b11, ^16'hFFFF, 1'b0);
    drive(2'b11);
    wait_drain();

`ifdef RX_PARITY_EN
    err_base = err_seen;
    exp_q.push_back(16'h0001);
    send_frame(16'h0001, 2'b11, 1'b1, 1'b0);
    drive(2'b11);
    wait_drain();
    check("p_good_no_err", err_seen - err_base, 0);
    send_frame(16'h0001, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    rx_pins = 2'b11;
    #1;
    check("p_bad_err", frame_err, 1);
    check("p_bad_no_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("p_bad_err_count", err_seen - err_base, 1);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rx_frame_receiver.md
# rx_frame_receiver

Deserializes frames arriving on the 2-bit serial receive pins into 16-bit words and buffers them for the synth/PPU register-write logic. Sits directly downstream of the top-level input register stage (consumes the registered `rx_pins`). Consumers read it through a valid/ready handshake. Malformed or unbufferable frames are flagged and dropped, never partially delivered.

## Interface

Parameters:
- `IO_BITS`, 2: serial pin count; only 2 is supported.
- `PAYLOAD_BITS`, 16: payload width; must be a multiple of `IO_BITS`.
- `DEPTH`, 2: FIFO entries; a power of 2, at least 1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `rx_pins`  in  IO_BITS  registered serial input; idle value 2'b11
- `out_data`  out  PAYLOAD_BITS  head-of-FIFO word
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head word when `out_valid` is also high
- `frame_err`  out  1  one-cycle pulse: frame rejected (stop or parity error)
- `overflow`  out  1  sticky: a good frame was dropped because the FIFO was full
- `clear_ovf`  in  1  clears `overflow`
- `busy`  out  1  receiver is inside a frame (state is not IDLE)

## Operation

- **Frame format:** 1 start symbol, then `PAYLOAD_BITS/IO_BITS` data symbols, an optional parity symbol, then 1 stop symbol. Every symbol lasts one clock.
  - Start symbol: `rx_pins[0]==0`; `rx_pins[1]` is ignored.
  - Data symbols: the first data symbol carries payload bits [1:0], the next [3:2], and so on (LSB first).
  - Stop symbol: must equal 2'b11.
- **FSM:**
  - IDLE → DATA when the start symbol is sampled.
  - DATA: a 3-bit symbol counter runs from 0 to 7. At 7, go to PARITY (if configured) or STOP.
  - PARITY → STOP.
  - STOP → IDLE unconditionally.
  - In IDLE, `rx_pins[0]==1` keeps the FSM in IDLE.
- **Stop sampled as 2'b11:** the frame is good.
  - It is pushed if FIFO count < `DEPTH`, or if a pop happens in the same cycle.
  - Otherwise `overflow` is set and the frame is dropped.
- **Stop sampled as anything else:** pulse `frame_err`; the frame is dropped.
- **`overflow`:**
  - Set has priority over `clear_ovf` when both occur in the same cycle.
  - `overflow` is only a flag; it never blocks later frames.
- **Pop:** occurs when `out_valid && out_ready`.
- **FIFO:** first-in first-out.
  - `out_data` shows the head entry.
  - While empty, `out_data` holds its last value (0 after reset).
- **Reset values:** `out_data`=0, `out_valid`=0, `frame_err`=0, `overflow`=0, `busy`=0, FIFO empty, FSM in IDLE.
- **Reset mid-frame:** the frame is abandoned with no push and no error pulse.

## Timing

- One symbol is sampled per clock edge. Frame length is 10 cycles, or 11 with parity.
- Latency: `out_valid` rises the cycle after the edge that samples a good stop symbol.
- `frame_err` is high for exactly the cycle after the bad stop/parity sample.
- Back-to-back frames: a start symbol may be sampled on the cycle immediately after stop. No idle gap is required.
- Simultaneous push and pop with count==`DEPTH`: both succeed and the count is unchanged.
- Simultaneous push and pop with count==0: not possible, because the pop requires `out_valid`.
- `busy` is registered from the FSM state and is high from the cycle after the start sample through the stop cycle.

## Configuration

- `RX_PARITY_EN` defined:
  - A PARITY state is inserted after the data symbols.
  - The parity symbol requires `rx_pins[0]` to equal the XOR of all payload bits (even parity), and `rx_pins[1]==1`.
  - On mismatch, the FSM still goes to STOP, then the frame is dropped with a `frame_err` pulse after the stop sample. No push occurs.
- `RX_PARITY_EN` not defined: there is no PARITY state and frames are 10 cycles long.

## Structure

- Shared package `rx_pkg` contains:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - `RX_IDLE_SYMBOL` = 2'b11;
  - `RX_SYMBOLS_PER_FRAME` = `PAYLOAD_BITS/IO_BITS`.
- Sub-module `rx_fifo`: a parameterized synchronous FIFO with push, pop, full, empty and head data, supporting push and pop in the same cycle when full.
- The FSM, shift register and error/overflow logic stay in `rx_frame_receiver`.

## Test plan

- **Single good frame, payload 0xA5C3, `out_ready`=1:** `out_valid` is high for 1 cycle, starting 1 cycle after the stop sample, with `out_data`=0xA5C3. No `frame_err`.
- **Bad stop symbol 2'b01 after payload 0x1234:** `frame_err` pulses once, and `out_valid` stays 0.
- **`DEPTH`=2, `out_ready`=0, three frames 0x0001/0x0002/0x0003:**
  - `overflow`=1 after the third stop sample.
  - Releasing `out_ready` then yields 0x0001 followed by 0x0002.
  - `clear_ovf` returns `overflow` to 0.
- **FIFO full, pop during the stop cycle of a new frame 0x0BEE:** no overflow, and 0x0BEE is delivered after the older entry.
- **`rst_n` low during data symbol 4, then released:** `busy`=0, no push, no error. A following frame 0xFFFF is received correctly.
- **With `RX_PARITY_EN`:**
  - Payload 0x0001 with parity bit 1 is accepted.
  - Payload 0x0001 with parity bit 0 gives a `frame_err` pulse and no push.
